alu_op_sequencer: RTL and testbench
===================================

// Module: alu_op_sequencer
// PURPOSE
//  Shares one 7-bit arithmetic unit between two requesters via round-robin arbitration.
//  Sequences multi-cycle ops: iterative divide/modulo and saturating power-of-ten.
//  Returns one 15-bit result per accepted command on a valid/ready response channel.
//  Sits between front-end operand sources (switches/UART) and the 7-seg display logic.
// PARAMETERS
//  W_IN   7   operand width
//  W_OUT  15  result width (2*W_IN+1)
// PORTS
//  clk          in   1      single system clock, rising edge
//  rst          in   1      asynchronous, active-high reset
//  req0_valid   in   1      requester 0 command valid
//  req0_ready   out  1      requester 0 command accepted this cycle
//  req0_sel     in   3      opcode
//  req0_a       in   7      operand A
//  req0_b       in   7      operand B
//  req1_*       -    -      identical set for requester 1
//  rsp_valid    out  1      result valid, held until rsp_ready
//  rsp_ready    in   1      consumer accepts result
//  rsp_id       out  1      requester index of this result
//  rsp_out      out  15     result
//  rsp_err      out  1      div/mod by zero or unsupported opcode
//  busy         out  1      state != IDLE
// BEHAVIOUR
//  Reset: state=IDLE; rsp_valid/rsp_id/rsp_out/rsp_err/busy=0; last_grant=1 (req0 wins first).
//  Opcodes: 000 add, 001 sub, 010 div, 011 mul, 100 mod, 101 cos, 110 pol, 111 pow.
//  IDLE: reqN_ready=1 only for the granted requester, only in IDLE; accept = valid&ready.
//   Both valid: grant != last_grant; one valid: grant it. Capture sel/a/b/id; update last_grant.
//  Latency from accept cycle N (rsp_valid first high):
//   add/sub/mul/cos/pol -> EXEC at N+1 -> rsp_valid at N+2.
//   div/mod -> DIV, 7 restoring iterations N+1..N+7 -> rsp_valid at N+8.
//   pow -> POW: acc=1, cnt=a; each cycle cnt==0 ? DONE : acc=sat(acc*10), cnt--;
//    rsp_valid at N+2+a (max N+129).
//  Arithmetic, operands zero-extended to 15 bits:
//   add a+b; sub a-b mod 2^15 (3-5 -> 15'h7FFE); mul a*b; div quotient; mod remainder.
//   pow: 10**a, saturating to 15'h7FFF once product > 32767 (a>=5); sat is sticky.
//   div/mod with b==0: rsp_out=15'h007F, rsp_err=1; DIV still runs 7 cycles.
//   cos/pol unsupported: rsp_out=0, rsp_err=1.
//  DONE: rsp_valid=1, outputs stable until rsp_valid&rsp_ready; then IDLE next cycle.
//   Earliest next accept is the cycle after response handshake; no overlap.
//  Requests arriving while busy are not acknowledged; requesters hold valid (no drop).
//  Changes on req inputs after accept have no effect on the command in flight.
//  rst asserted mid-operation: immediate return to reset values; in-flight result discarded.
//  States: IDLE, EXEC, DIV, POW, DONE; binary encoded; illegal state -> IDLE.
// STRUCTURE
//  Shared package alu_seq_pkg: opcode localparams (OP_ADD..OP_POW), state encodings,
//   W_IN/W_OUT, SAT_MAX=15'h7FFF, DIV_ITERS=7.
//  Sub-module alu_seq_divider: 7-cycle restoring divider, start/done, quot/rem/dz flag.
//  Top holds arbiter, FSM, power loop, response register.
// TESTING
//  add: req0 a=100,b=27 -> rsp_out=127, id=0, err=0, rsp_valid 2 cycles after accept.
//  sub/mul: a=3,b=5 sub -> 15'h7FFE; a=127,b=127 mul -> 16129.
//  div/mod: a=100,b=7 -> quot 14 at N+8; mod -> 2; b=0 -> 15'h007F, err=1, at N+8.
//  pow: a=0 -> 1 at N+2; a=4 -> 10000 at N+6; a=6 -> 15'h7FFF at N+8.
//  arbitration: both valid continuously -> grants alternate 0,1,0,1; rsp_ready held low 5
//   cycles -> rsp stable, no new accept until handshake.
//  reset mid-DIV at N+3 -> all outputs 0 same cycle; next request served with req0 priority.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU operation sequencer: widths, opcodes, FSM states
// and the saturating power-of-ten step.
package alu_seq_pkg;

  localparam int W_IN      = 7;
  localparam int W_OUT     = 2 * W_IN + 1;
  localparam int DIV_ITERS = 7;

  localparam logic [W_OUT-1:0] SAT_MAX      = 15'h7FFF;
  localparam logic [W_OUT-1:0] DIV_ZERO_OUT = 15'h007F;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_DIV = 3'b010;
  localparam logic [2:0] OP_MUL = 3'b011;
  localparam logic [2:0] OP_MOD = 3'b100;
  localparam logic [2:0] OP_COS = 3'b101;
  localparam logic [2:0] OP_POL = 3'b110;
  localparam logic [2:0] OP_POW = 3'b111;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_EXEC = 3'd1,
    ST_DIV  = 3'd2,
    ST_POW  = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  // Once the accumulator reaches SAT_MAX every further step stays there.
  function automatic logic [W_OUT-1:0] sat_mul10(input logic [W_OUT-1:0] x);
    logic [W_OUT+3:0] p;
    p = {4'b0000, x} * 19'd10;
    return (p > {4'b0000, SAT_MAX}) ? SAT_MAX : p[W_OUT-1:0];
  endfunction

endpackage

// File: rtl/alu_seq_if.sv
// Request/response bundle between the two operand sources, the sequencer and
// the display-side consumer.
interface alu_seq_if;
  import alu_seq_pkg::*;

  logic             req0_valid, req0_ready;
  logic [2:0]       req0_sel;
  logic [W_IN-1:0]  req0_a, req0_b;
  logic             req1_valid, req1_ready;
  logic [2:0]       req1_sel;
  logic [W_IN-1:0]  req1_a, req1_b;
  logic             rsp_valid, rsp_ready, rsp_id, rsp_err, busy;
  logic [W_OUT-1:0] rsp_out;

  modport slave (
    input  req0_valid, req0_sel, req0_a, req0_b,
    input  req1_valid, req1_sel, req1_a, req1_b, rsp_ready,
    output req0_ready, req1_ready, rsp_valid, rsp_id, rsp_out, rsp_err, busy
  );

  modport master (
    output req0_valid, req0_sel, req0_a, req0_b,
    output req1_valid, req1_sel, req1_a, req1_b, rsp_ready,
    input  req0_ready, req1_ready, rsp_valid, rsp_id, rsp_out, rsp_err, busy
  );
endinterface

// File: rtl/alu_seq_divider.sv
// Restoring divider: loads on start, then performs one quotient bit per cycle.
// done flags the final iteration; quot/rem show that iteration's result.
module alu_seq_divider
  import alu_seq_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [W_IN-1:0] dividend,
  input  logic [W_IN-1:0] divisor,
  output logic            done,
  output logic [W_IN-1:0] quot,
  output logic [W_IN-1:0] rem,
  output logic            dz
);

  logic [W_IN-1:0] rem_q, quot_q, dvs_q;
  logic [2:0]      cnt_q;
  logic [W_IN:0]   shifted, trial;
  logic            fits;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    shifted = {rem_q, quot_q[W_IN-1]};
    trial   = shifted - {1'b0, dvs_q};
    fits    = (shifted >= {1'b0, dvs_q});
    rem     = fits ? trial[W_IN-1:0] : shifted[W_IN-1:0];
    quot    = {quot_q[W_IN-2:0], fits};
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem_q  <= '0;
      quot_q <= '0;
      dvs_q  <= '0;
      cnt_q  <= '0;
    end else if (start) begin
      rem_q  <= '0;
      quot_q <= dividend;
      dvs_q  <= divisor;
      cnt_q  <= 3'(DIV_ITERS);
    end else if (cnt_q != 3'd0) begin
      rem_q  <= rem;
      quot_q <= quot;
      cnt_q  <= cnt_q - 3'd1;
    end
  end

  assign done = (cnt_q == 3'd1);
  assign dz   = (dvs_q == '0);

endmodule

// File: rtl/alu_op_sequencer.sv
// Round-robin shared ALU: arbitrates two requesters, sequences single-cycle,
// divide/modulo and power-of-ten operations, and holds one result until taken.
module alu_op_sequencer
  import alu_seq_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  alu_seq_if.slave  bus
);

  state_t           state_q, state_d;
  logic             last_grant_q, grant, accept, div_start;
  logic [2:0]       sel_in, op_sel_q;
  logic [W_IN-1:0]  a_in, b_in, op_a_q, op_b_q;
  logic [W_OUT-1:0] acc_q, exec_out, rsp_out_q;
  logic             exec_err, rsp_err_q, rsp_id_q;
  logic             div_done, div_dz;
  logic [W_IN-1:0]  div_quot, div_rem;

  always_comb begin
    if (bus.req0_valid && bus.req1_valid) grant = ~last_grant_q;
    else if (bus.req0_valid)              grant = 1'b0;
    else if (bus.req1_valid)              grant = 1'b1;
    else                                  grant = ~last_grant_q;
    sel_in = grant ? bus.req1_sel : bus.req0_sel;
    a_in   = grant ? bus.req1_a   : bus.req0_a;
    b_in   = grant ? bus.req1_b   : bus.req0_b;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d        = state_q;
    bus.req0_ready = 1'b0;
    bus.req1_ready = 1'b0;
    accept         = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        bus.req0_ready = ~grant;
        bus.req1_ready = grant;
        accept = grant ? bus.req1_valid : bus.req0_valid;
        if (accept) begin
          if (sel_in == OP_DIV || sel_in == OP_MOD) state_d = ST_DIV;
          else if (sel_in == OP_POW)                state_d = ST_POW;
          else                                      state_d = ST_EXEC;
        end
      end
      ST_EXEC: state_d = ST_DONE;
      ST_DIV:  if (div_done)         state_d = ST_DONE;
      ST_POW:  if (op_a_q == '0)     state_d = ST_DONE;
      ST_DONE: if (bus.rsp_ready)    state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign div_start = accept && (sel_in == OP_DIV || sel_in == OP_MOD);

  always_comb begin
    exec_out = '0;
    exec_err = 1'b0;
    case (op_sel_q)
      OP_ADD:  exec_out = W_OUT'(op_a_q) + W_OUT'(op_b_q);
      OP_SUB:  exec_out = W_OUT'(op_a_q) - W_OUT'(op_b_q);
      OP_MUL:  exec_out = W_OUT'(op_a_q) * W_OUT'(op_b_q);
      default: exec_err = 1'b1;
    endcase
  end

  // The captured operand A doubles as the power loop's remaining-step counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant_q <= 1'b1;
      op_sel_q     <= '0;
      op_a_q       <= '0;
      op_b_q       <= '0;
      acc_q        <= '0;
      rsp_out_q    <= '0;
      rsp_err_q    <= 1'b0;
      rsp_id_q     <= 1'b0;
    end else begin
      if (accept) begin
        last_grant_q <= grant;
        op_sel_q     <= sel_in;
        op_a_q       <= a_in;
        op_b_q       <= b_in;
        rsp_id_q     <= grant;
        acc_q        <= W_OUT'(1);
      end
      case (state_q)
        ST_EXEC: begin
          rsp_out_q <= exec_out;
          rsp_err_q <= exec_err;
        end
        ST_DIV: if (div_done) begin
          rsp_err_q <= div_dz;
          if (div_dz)                  rsp_out_q <= DIV_ZERO_OUT;
          else if (op_sel_q == OP_MOD) rsp_out_q <= W_OUT'(div_rem);
          else                         rsp_out_q <= W_OUT'(div_quot);
        end
        ST_POW: begin
          if (op_a_q == '0) begin
            rsp_out_q <= acc_q;
            rsp_err_q <= 1'b0;
          end else begin
            acc_q  <= sat_mul10(acc_q);
            op_a_q <= op_a_q - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  alu_seq_divider u_div (
    .clk      (clk),
    .rst      (rst),
    .start    (div_start),
    .dividend (a_in),
    .divisor  (b_in),
    .done     (div_done),
    .quot     (div_quot),
    .rem      (div_rem),
    .dz       (div_dz)
  );

  assign bus.rsp_valid = (state_q == ST_DONE);
  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.rsp_out   = rsp_out_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.rsp_id    = rsp_id_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed and randomized bench for alu_op_sequencer against a behavioural
// model of results, latency and round-robin grant order.
module tb_alu_op_sequencer;
  import alu_seq_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_seq_if bus();

  alu_op_sequencer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;
  int model_last;

  logic [2:0] cur_sel [2];
  logic [6:0] cur_a   [2];
  logic [6:0] cur_b   [2];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void model(input logic [2:0] sel, input int a, input int b,
                                output int out, output bit err, output int lat);
    int p;
    out = 0; err = 0; lat = 2;
    case (sel)
      OP_ADD: out = a + b;
      OP_SUB: out = (a - b) & 32'h7FFF;
      OP_MUL: out = a * b;
      OP_DIV, OP_MOD: begin
        lat = 8;
        if (b == 0) begin out = 32'h7F; err = 1; end
        else out = (sel == OP_DIV) ? a / b : a % b;
      end
      OP_POW: begin
        lat = 2 + a;
        p = 1;
        for (int i = 0; i < a; i++) begin
          p = p * 10;
          if (p > 32767) p = 32767;
        end
        out = p;
      end
      default: err = 1;
    endcase
  endfunction

  task automatic drive(input int r, input bit v, input logic [2:0] sel,
                       input logic [6:0] a, input logic [6:0] b);
    if (r == 0) begin
      bus.req0_valid = v; bus.req0_sel = sel; bus.req0_a = a; bus.req0_b = b;
    end else begin
      bus.req1_valid = v; bus.req1_sel = sel; bus.req1_a = a; bus.req1_b = b;
    end
  endtask

  function automatic bit accepted(input int r);
    return (r == 0) ? (bus.req0_valid && bus.req0_ready) : (bus.req1_valid && bus.req1_ready);
  endfunction

  // Waits for rsp_valid (k counts negedges since accept), checks it, holds
  // rsp_ready low for 'hold' cycles, then completes the handshake.
  task automatic wait_rsp(input string tag, input int r, input int out, input bit err,
                          input int lat, input int hold);
    int k = 1;
    bit seen = 0;
    for (int i = 0; i < 200; i++) begin
      #1;
      if (bus.rsp_valid) begin seen = 1; break; end
      @(negedge clk);
      k++;
    end
    check({tag, " rsp_valid seen"}, 32'(seen), 1);
    if (!seen) return;
    check({tag, " latency"}, k, lat);
    check({tag, " rsp_out"}, 32'(bus.rsp_out), out);
    check({tag, " rsp_err"}, 32'(bus.rsp_err), 32'(err));
    check({tag, " rsp_id"}, 32'(bus.rsp_id), r);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      #1;
      check({tag, " hold valid"}, 32'(bus.rsp_valid), 1);
      check({tag, " hold out"}, 32'(bus.rsp_out), out);
      check({tag, " hold no ready"}, {bus.req0_ready, bus.req1_ready}, 0);
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    #1;
    check({tag, " idle after handshake"}, 32'(bus.busy), 0);
  endtask

  task automatic do_cmd(input string tag, input int r, input logic [2:0] sel,
                        input logic [6:0] a, input logic [6:0] b, input int hold);
    int out, lat;
    bit err, seen;
    model(sel, a, b, out, err, lat);
    drive(r, 1'b1, sel, a, b);
    seen = 0;
    for (int i = 0; i < 50; i++) begin
      #1;
      if (accepted(r)) begin seen = 1; break; end
      @(negedge clk);
    end
    check({tag, " accept"}, 32'(seen), 1);
    if (!seen) begin drive(r, 1'b0, sel, a, b); return; end
    model_last = r;
    @(negedge clk);
    // Scramble the request fields to show the in-flight command is unaffected.
    drive(r, 1'b0, 3'($urandom), 7'($urandom), 7'($urandom));
    wait_rsp(tag, r, out, err, lat, hold);
  endtask

  initial begin
    int out, lat, got, exp_g;
    bit err, seen;

    rst = 1'b1;
    bus.rsp_ready = 1'b0;
    drive(0, 1'b0, 3'd0, 7'd0, 7'd0);
    drive(1, 1'b0, 3'd0, 7'd0, 7'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    model_last = 1;
    #1;
    check("reset rsp_valid", 32'(bus.rsp_valid), 0);
    check("reset busy", 32'(bus.busy), 0);
    check("reset rsp_out", 32'(bus.rsp_out), 0);
    check("reset rsp_err", 32'(bus.rsp_err), 0);
    check("reset rsp_id", 32'(bus.rsp_id), 0);
    check("reset req0 first", {bus.req0_ready, bus.req1_ready}, 32'b10);
    @(negedge clk);

    do_cmd("add", 0, OP_ADD, 7'd100, 7'd27, 0);
    do_cmd("sub", 0, OP_SUB, 7'd3, 7'd5, 0);
    do_cmd("mul", 1, OP_MUL, 7'd127, 7'd127, 0);
    do_cmd("div", 0, OP_DIV, 7'd100, 7'd7, 0);
    do_cmd("mod", 1, OP_MOD, 7'd100, 7'd7, 0);
    do_cmd("div0", 0, OP_DIV, 7'd55, 7'd0, 0);
    do_cmd("mod0", 0, OP_MOD, 7'd55, 7'd0, 0);
    do_cmd("pow0", 0, OP_POW, 7'd0, 7'd9, 0);
    do_cmd("pow4", 1, OP_POW, 7'd4, 7'd0, 0);
    do_cmd("pow6", 0, OP_POW, 7'd6, 7'd0, 0);
    do_cmd("pow127", 1, OP_POW, 7'd127, 7'd0, 0);
    do_cmd("cos", 0, OP_COS, 7'd12, 7'd34, 0);
    do_cmd("pol", 1, OP_POL, 7'd56, 7'd78, 0);
    do_cmd("hold5", 0, OP_ADD, 7'd9, 7'd8, 5);

    // Both requesters valid continuously: grants must alternate.
    for (int r = 0; r < 2; r++) begin
      cur_sel[r] = 3'($urandom); cur_a[r] = 7'($urandom_range(0, 12)); cur_b[r] = 7'($urandom);
      drive(r, 1'b1, cur_sel[r], cur_a[r], cur_b[r]);
    end
    for (int g = 0; g < 6; g++) begin
      exp_g = 1 - model_last;
      seen = 0;
      for (int i = 0; i < 50; i++) begin
        #1;
        if (accepted(0) || accepted(1)) begin seen = 1; break; end
        @(negedge clk);
      end
      check("arb accept", 32'(seen), 1);
      if (!seen) break;
      got = accepted(1) ? 1 : 0;
      check("arb grant", got, exp_g);
      model(cur_sel[got], cur_a[got], cur_b[got], out, err, lat);
      model_last = got;
      @(negedge clk);
      cur_sel[got] = 3'($urandom); cur_a[got] = 7'($urandom_range(0, 12)); cur_b[got] = 7'($urandom);
      drive(got, 1'b1, cur_sel[got], cur_a[got], cur_b[got]);
      wait_rsp("arb", got, out, err, lat, g % 3);
    end
    drive(0, 1'b0, 3'd0, 7'd0, 7'd0);
    drive(1, 1'b0, 3'd0, 7'd0, 7'd0);
    @(negedge clk);

    for (int n = 0; n < 30; n++) begin
      logic [6:0] rb;
      rb = ($urandom_range(0, 5) == 0) ? 7'd0 : 7'($urandom);
      do_cmd("rand", int'($urandom_range(0, 1)), 3'($urandom), 7'($urandom), rb,
             int'($urandom_range(0, 2)));
    end

    // Reset three cycles into a divide from requester 1.
    drive(1, 1'b1, OP_DIV, 7'd100, 7'd7);
    seen = 0;
    for (int i = 0; i < 50; i++) begin
      #1;
      if (accepted(1)) begin seen = 1; break; end
      @(negedge clk);
    end
    check("rstdiv accept", 32'(seen), 1);
    repeat (3) @(negedge clk);
    drive(1, 1'b0, 3'd0, 7'd0, 7'd0);
    check("rstdiv busy before", 32'(bus.busy), 1);
    rst = 1'b1;
    #1;
    check("rstdiv rsp_valid", 32'(bus.rsp_valid), 0);
    check("rstdiv busy", 32'(bus.busy), 0);
    check("rstdiv rsp_out", 32'(bus.rsp_out), 0);
    check("rstdiv rsp_err", 32'(bus.rsp_err), 0);
    check("rstdiv rsp_id", 32'(bus.rsp_id), 0);
    @(negedge clk);
    rst = 1'b0;
    model_last = 1;
    drive(0, 1'b1, OP_ADD, 7'd1, 7'd2);
    drive(1, 1'b1, OP_SUB, 7'd9, 7'd2);
    #1;
    check("post-reset req0 priority", {bus.req0_ready, bus.req1_ready}, 32'b10);
    drive(1, 1'b0, 3'd0, 7'd0, 7'd0);
    do_cmd("post-reset add", 0, OP_ADD, 7'd1, 7'd2, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
